// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Define MULDIV_DIVIDE_EN to build the divider; otherwise divide ops complete at once with div_by_zero.
module muldiv_hilo_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                          r_state, w_state_nxt;
    logic                            w_busy, w_accept, w_finish, w_skip, w_signed;
    logic [CNT_W-1:0]                r_cnt;
    logic [WIDTH-1:0]                r_opd, r_acc, r_q, r_hi_out, r_lo_out;
    logic                            r_neg_q, r_skip, r_done, r_dz;
    logic [WIDTH+BITS_PER_CYCLE-1:0] w_pp, w_sum;
    logic [WIDTH-1:0]                w_acc_nxt, w_q_nxt;
    logic [2*WIDTH-1:0]              w_prod_fix;
`ifdef MULDIV_DIVIDE_EN
    logic                            r_is_div, r_neg_r;
    logic [WIDTH-1:0]                w_rem, w_quo;
    logic [WIDTH:0]                  w_trial;
`endif

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_sign_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_signed = ~op[0];
`ifdef MULDIV_DIVIDE_EN
    assign w_skip = op[1] && (b == '0);
`else
    assign w_skip = op[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Cancel wins over start in IDLE and aborts RUN/FIX without a done pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_skip ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (cancel)             w_state_nxt = S_IDLE;
                else if (r_cnt == '0)   w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
                w_finish    = !cancel;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_busy = (r_state != S_IDLE);

    // Shift-add multiply: add opd * low digit of multiplier, then shift {acc,q} right one digit.
    assign w_pp  = {{BITS_PER_CYCLE{1'b0}}, r_opd} * {{WIDTH{1'b0}}, r_q[BITS_PER_CYCLE-1:0]};
    assign w_sum = {{BITS_PER_CYCLE{1'b0}}, r_acc} + w_pp;

`ifdef MULDIV_DIVIDE_EN
    // Restoring division, one quotient bit per inner iteration.
    always_comb begin
        w_rem   = r_acc;
        w_quo   = r_q;
        w_trial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_trial = {w_rem, w_quo[WIDTH-1]};
            w_quo   = w_quo << 1;
            if (w_trial >= {1'b0, r_opd}) begin
                w_trial  = w_trial - {1'b0, r_opd};
                w_quo[0] = 1'b1;
            end
            w_rem = w_trial[WIDTH-1:0];
        end
    end
`endif

    always_comb begin
        w_acc_nxt = w_sum[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
        w_q_nxt   = WIDTH'({w_sum[BITS_PER_CYCLE-1:0], r_q} >> BITS_PER_CYCLE);
`ifdef MULDIV_DIVIDE_EN
        if (r_is_div) begin
            w_acc_nxt = w_rem;
            w_q_nxt   = w_quo;
        end
`endif
    end

    assign w_prod_fix = f_sign_wide({r_acc, r_q}, r_neg_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_neg_q  <= 1'b0;
            r_skip   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi_out <= '0;
            r_lo_out <= '0;
`ifdef MULDIV_DIVIDE_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= w_finish;
            r_dz   <= w_finish && r_skip;
            if (w_accept) begin
                r_cnt   <= CNT_LAST;
                r_skip  <= w_skip;
                r_neg_q <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_acc   <= '0;
`ifdef MULDIV_DIVIDE_EN
                r_is_div <= op[1];
                r_neg_r  <= w_signed && a[WIDTH-1];
                r_opd    <= op[1] ? f_mag(b, w_signed) : f_mag(a, w_signed);
                r_q      <= op[1] ? f_mag(a, w_signed) : f_mag(b, w_signed);
`else
                r_opd    <= f_mag(a, w_signed);
                r_q      <= f_mag(b, w_signed);
`endif
            end else if (r_state == S_RUN && !cancel) begin
                r_cnt <= r_cnt - CNT_W'(1);
                r_acc <= w_acc_nxt;
                r_q   <= w_q_nxt;
            end

            if (w_finish && !r_skip) begin
`ifdef MULDIV_DIVIDE_EN
                if (r_is_div) begin
                    r_hi_out <= f_sign(r_acc, r_neg_r);
                    r_lo_out <= f_sign(r_q, r_neg_q);
                end else begin
                    {r_hi_out, r_lo_out} <= w_prod_fix;
                end
`else
                {r_hi_out, r_lo_out} <= w_prod_fix;
`endif
            end else if (!w_busy) begin
                if (hi_wr) r_hi_out <= wr_data;
                if (lo_wr) r_lo_out <= wr_data;
            end
        end
    end

    assign busy        = w_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign hi_out      = r_hi_out;
    assign lo_out      = r_lo_out;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit at WIDTH=32, BITS_PER_CYCLE=1; follows MULDIV_DIVIDE_EN.
module tb_muldiv_hilo_unit;
    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, cancel = 1'b0, hi_wr = 1'b0, lo_wr = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wr_data = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi_out, lo_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_hilo_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int nbusy, output logic dz);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = $urandom; b = $urandom;
        lat = 0; nbusy = 0; dz = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = j;
                dz  = div_by_zero;
                break;
            end
        end
    endtask

    task automatic run_chk(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input int e_lat, input logic e_dz,
                           input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
        int lat, nb;
        logic dz;
        do_op(o, x, y, lat, nb, dz);
        chk({tag, "_lat"},  lat, e_lat);
        chk({tag, "_busy"}, nb, e_lat - 1);
        chk({tag, "_dz"},   dz, e_dz);
        chk({tag, "_hi"},   hi_out, e_hi);
        chk({tag, "_lo"},   lo_out, e_lo);
    endtask

    task automatic mt_write(input logic [W-1:0] h, input logic [W-1:0] l);
        wr_data = h; hi_wr = 1'b1;
        @(negedge clk);
        hi_wr = 1'b0; wr_data = l; lo_wr = 1'b1;
        @(negedge clk);
        lo_wr = 1'b0;
    endtask

    initial begin
        int nd, nb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz",   div_by_zero, 0);
        chk("rst_hi",   hi_out, 0);
        chk("rst_lo",   lo_out, 0);

        run_chk("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 34, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        @(negedge clk);
        chk("done_pulse", done, 0);
        run_chk("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run_chk("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000, 34, 1'b0, 32'h40000000, 32'h0);
        run_chk("mult_m1", OP_MULT, 32'd5, 32'hFFFFFFFF, 34, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFB);

        mt_write(32'h12345678, 32'h9ABCDEF0);
        chk("mthi", hi_out, 32'h12345678);
        chk("mtlo", lo_out, 32'h9ABCDEF0);
        run_chk("divu_zero", OP_DIVU, 32'd7, 32'd0, 2, 1'b1, 32'h12345678, 32'h9ABCDEF0);
`ifdef MULDIV_DIVIDE_EN
        run_chk("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'd2, 34, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_chk("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 34, 1'b0, 32'h0, 32'h80000000);
        run_chk("div_nd",   OP_DIV,  32'd7, 32'hFFFFFFFE, 34, 1'b0, 32'h1, 32'hFFFFFFFD);
        run_chk("divu_9_3", OP_DIVU, 32'd9, 32'd3, 34, 1'b0, 32'h0, 32'h3);
        run_chk("divu_rem", OP_DIVU, 32'd100, 32'd7, 34, 1'b0, 32'h2, 32'hE);
`else
        run_chk("div_off",  OP_DIV,  32'hFFFFFFF9, 32'd2, 2, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        run_chk("divu_off", OP_DIVU, 32'd9, 32'd3, 2, 1'b1, 32'h12345678, 32'h9ABCDEF0);
`endif

        // cancel at k+10 with an ignored start and MTHI/MTLO while busy
        mt_write(32'hCAFEF00D, 32'h0BADBEEF);
        op = OP_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            start   = (j == 3);
            hi_wr   = (j == 3);
            lo_wr   = (j == 3);
            wr_data = 32'h11111111;
            cancel  = (j == 10);
        end
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", busy, 0);
        nd = 0; nb = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        chk("cancel_nodone", nd, 0);
        chk("cancel_idle", nb, 0);
        chk("cancel_hi", hi_out, 32'hCAFEF00D);
        chk("cancel_lo", lo_out, 32'h0BADBEEF);

        // reset in the middle of an operation
        op = OP_MULTU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            rst = (j == 5);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_dz",   div_by_zero, 0);
        chk("mrst_hi",   hi_out, 0);
        chk("mrst_lo",   lo_out, 0);
        run_chk("after_rst", OP_MULTU, 32'd6, 32'd7, 34, 1'b0, 32'h0, 32'h2A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
